rv_multicycle_ctrl: RTL
=======================

Name: rv_multicycle_ctrl

Overview:
- Control FSM that sequences the instruction decoder, register file, ALU and one shared instruction/data memory port.
- Turns the datapath into a multi-cycle RV32I core.
- Consumes the decoded opcode/fn3 and the ALU branch flag; emits per-cycle enables and mux selects.
- Arbitrates the single memory port between instruction fetch and load/store; counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before raising a bus error (range 1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction opcode from the decoder, instruction bits [6:0].
- fn3  in  3  funct3 field from the decoder.
- br_taken  in  1  ALU branch-condition result, valid in EXEC.
- mem_ready  in  1  memory acknowledges the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write strobe; only ever high with mem_req in MEM for stores.
- addr_sel  out  1  0 = PC drives the address, 1 = ALU result drives it.
- ir_we  out  1  latch fetched word into the instruction register.
- rf_we  out  1  register-file write enable.
- wb_sel  out  2  write-back source: 00 ALU, 01 memory data, 10 PC+4, 11 immediate (LUI).
- pc_we  out  1  PC update enable.
- pc_sel  out  2  next PC: 00 PC+4, 01 PC+imm (branch/JAL), 10 ALU (JALR, low bit cleared).
- illegal  out  1  sticky: unsupported opcode was decoded.
- bus_err  out  1  sticky: memory timeout.
- instret  out  CNT_W  retired-instruction count.
- state_o  out  3  current state, for debug.

Behaviour:
- States are encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (asynchronous) gives:
  - state FETCH.
  - instret 0, illegal 0, bus_err 0.
  - Wait counter 0.
  - Every enable/strobe 0, all selects 0.
- Outputs are Moore-style from state plus registered inputs, except:
  - ir_we, pc_we and rf_we qualify combinationally on mem_ready or br_taken as listed below.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1 that cycle, go to DECODE.
  - Otherwise stay.
- DECODE: one cycle. Legal opcodes go to EXEC: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode sets illegal and goes to TRAP.
- EXEC, per opcode class:
  - Branch: pc_we=1. pc_sel=01 if br_taken, else 00. instret++, go to FETCH. fn3 is passed through and not checked here.
  - Load/store: go to MEM.
  - All other classes: go to WB.
- MEM:
  - mem_req=1, addr_sel=1. mem_we=1 when opcode=0100011.
  - On mem_ready, store: pc_we=1, pc_sel=00, instret++, go to FETCH.
  - On mem_ready, load: go to WB.
- WB:
  - rf_we=1 and pc_we=1.
  - wb_sel by class: R/I/AUIPC → 00, load → 01, JAL/JALR → 10, LUI → 11.
  - pc_sel by class: JAL → 01, JALR → 10, else 00.
  - instret++, go to FETCH.
- Minimum latency per instruction class, with mem_ready immediate:
  - Branch: 3 cycles.
  - ALU/LUI/AUIPC/jumps: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Memory timeout:
  - The wait counter increments on every FETCH or MEM cycle without mem_ready, and clears on mem_ready or state change.
  - When it reaches MEM_TIMEOUT: set bus_err, drop mem_req next cycle, go to TRAP.
- TRAP: all enables 0; remain until rst. illegal and bus_err stay asserted.
- instret wraps from all-ones to 0 silently.
- Reset mid-operation, including an outstanding mem_req: everything returns immediately to reset values. No write strobe is permitted after rst rises.
- mem_we must never be high outside MEM. pc_we and rf_we must never be high in the same cycle as mem_req in FETCH.

Decomposition:
- Shared package rv_pkg holds:
  - Opcode constants, named by the decoder's categories: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - state_t enum.
  - wb_sel_t and pc_sel_t enums.
- The decoder imports the same opcode constants.
- One natural sub-module, rv_mem_wdog: the timeout counter.
  - Inputs: clk, rst, waiting, mem_ready.
  - Output: timeout.

Test Plan:
- R-type: opcode 0110011, mem_ready tied 1 → states 0,1,2,4,0. rf_we=1 with wb_sel=00 in cycle 4. instret 0→1.
- Load then store: opcode 0000011, then 0100011, mem_ready delayed 2 cycles in MEM each time.
  - mem_req held 3 cycles each. mem_we=1 only for the store.
  - Load: wb_sel=01. Store: no rf_we.
  - instret=2.
- Branch twice: br_taken=1 then br_taken=0 → pc_sel=01 then 00, pc_we=1 in EXEC, no rf_we. Each takes 3 cycles.
- JALR: opcode 1100111 → WB with wb_sel=10, pc_sel=10. JAL: opcode 1101111 → wb_sel=10, pc_sel=01.
- Illegal opcode 1111111 → illegal=1 in cycle after DECODE; state 5 persists 20 cycles; no enables asserted.
- Timeout: mem_ready held 0 in FETCH with MEM_TIMEOUT=4 → bus_err=1 after 4 waiting cycles, TRAP. Assert rst mid-wait in a second run → all outputs return to 0 immediately, state 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I control path:
// opcode constants, FSM states, datapath select encodings.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_ALU   = 2'b10
    } pc_sel_t;

    typedef enum logic [3:0] {
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_ILL
    } cls_t;

    function automatic cls_t op_class(input logic [6:0] op);
        cls_t c;
        case (op)
            OP_R:      c = C_R;
            OP_I:      c = C_I;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_BRANCH: c = C_BRANCH;
            OP_JAL:    c = C_JAL;
            OP_JALR:   c = C_JALR;
            OP_LUI:    c = C_LUI;
            OP_AUIPC:  c = C_AUIPC;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_mem_wdog.sv
// Memory-port watchdog: counts consecutive unacknowledged request
// cycles and flags a timeout on the last permitted one.
module rv_mem_wdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       stall;

    assign stall = waiting && !mem_ready;

    always_comb begin
        cnt_d = 8'd0;
        if (stall) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires in the cycle the counter would reach MEM_TIMEOUT.
    assign timeout = stall && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb,
// owns the shared memory port and counts retired instructions.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       fn3,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    state_t           state_q;
    state_t           state_d;
    cls_t             cls_q;
    cls_t             cls_d;
    logic             illegal_q;
    logic             illegal_d;
    logic             bus_err_q;
    logic             bus_err_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             retire;
    logic             waiting;
    logic             timeout;
    logic             unused_fn3;

    // Branch condition is resolved by the ALU; funct3 only matters there.
    assign unused_fn3 = ^fn3;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

    rv_mem_wdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .waiting  (waiting),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;

        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d = op_class(opcode);
                if (cls_d == C_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (cls_q)
                    C_LOAD: wb_sel = WB_MEM;
                    C_LUI:  wb_sel = WB_IMM;
                    C_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    C_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_ALU;
                    end
                    default: wb_sel = WB_ALU;
                endcase
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        // Reset silences the port at once, even mid-request.
        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_we    = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = WB_ALU;
            pc_we    = 1'b0;
            pc_sel   = PC_PLUS4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;
    assign state_o = state_q;

endmodule
